// File: rtl/pad_ctrl_tx.sv
// pad_ctrl_tx: serialises one controller snapshot (key/joy/trig) into a
// UART-style frame on a single line: start bit, 80 data bits LSB first
// (in_key[0] first), even parity, stop bit, then an idle-high gap before
// the next snapshot can be accepted.
module pad_ctrl_tx #(
    parameter int CLK_DIV  = 16,
    parameter int GAP_BITS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_key,
    input  logic [31:0] in_joy,
    input  logic [15:0] in_trig,
    output logic        tx_line,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] DIV_PRE  = 16'(CLK_DIV - 2);
    localparam logic [3:0]  GAP_LAST = 4'(GAP_BITS - 1);
    localparam logic [6:0]  BIT_LAST = 7'd79;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_GAP
    } state_t;

    state_t      state_q;
    logic [15:0] div_q;
    logic [15:0] div_d;
    logic [6:0]  bit_q;
    logic [3:0]  gap_q;
    logic [79:0] shift_q;
    logic        par_q;
    logic        tx_q;
    logic        ready_q;
    logic        busy_q;
    logic        done_q;
    logic        accept;
    logic        div_last;
    logic [79:0] payload;

    // XOR of all payload bits: the bit that makes payload+parity even
    function automatic logic even_parity(input logic [79:0] v);
        return ^v;
    endfunction

    assign payload  = {in_trig, in_joy, in_key};
    assign accept   = in_valid && ready_q;
    assign div_last = (div_q == DIV_LAST);

    // Bit-period counter next value: wraps exactly on the bit boundary
    always_comb begin
        div_d = div_last ? 16'd0 : div_q + 16'd1;
    end

    // Control FSM: sequences the frame and drives every output from a register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    div_q   <= '0;
                    ready_q <= 1'b1;
                    if (accept) begin
                        state_q <= S_START;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        tx_q    <= 1'b0;
                    end
                end
                S_START: begin
                    div_q <= div_d;
                    if (div_last) begin
                        state_q <= S_DATA;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                    end
                end
                S_DATA: begin
                    div_q <= div_d;
                    if (div_last) begin
                        if (bit_q == BIT_LAST) begin
                            state_q <= S_PARITY;
                            tx_q    <= par_q;
                        end else begin
                            bit_q <= bit_q + 7'd1;
                            tx_q  <= shift_q[1];
                        end
                    end
                end
                S_PARITY: begin
                    div_q <= div_d;
                    if (div_last) begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end
                end
                S_STOP: begin
                    div_q <= div_d;
                    // registered pulse lands in the final stop-bit cycle
                    if (div_q == DIV_PRE) done_q <= 1'b1;
                    if (div_last) begin
                        if (GAP_BITS == 0) begin
                            state_q <= S_IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_GAP;
                            gap_q   <= '0;
                        end
                    end
                end
                S_GAP: begin
                    div_q <= div_d;
                    if (div_last) begin
                        if (gap_q == GAP_LAST) begin
                            state_q <= S_IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            gap_q <= gap_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Payload shifter and parity latch; pure data, so no reset is needed
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && accept) begin
            shift_q <= payload;
            par_q   <= even_parity(payload);
        end else if (state_q == S_DATA && div_last) begin
            shift_q <= {1'b0, shift_q[79:1]};
        end
    end

    assign in_ready   = ready_q;
    assign tx_line    = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_pad_ctrl_tx.sv
// Bench for pad_ctrl_tx: three instances with different timing parameters,
// a cycle-level frame model, a mid-bit sampling receiver, directed checks.
module tb_pad_ctrl_tx;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst   [N];
    logic        valid [N];
    logic [31:0] key   [N];
    logic [31:0] joy   [N];
    logic [15:0] trig  [N];
    logic        ready [N];
    logic        tx    [N];
    logic        busy  [N];
    logic        done  [N];

    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   cyc    = 0;
    int   base   = 0;
    logic chk_en = 1'b0;

    // instance 0: CLK_DIV=4 GAP=2, instance 1: CLK_DIV=16 GAP=2, instance 2: CLK_DIV=2 GAP=0
    pad_ctrl_tx #(.CLK_DIV(4), .GAP_BITS(2)) u0 (
        .clk(clk), .reset(rst[0]), .in_valid(valid[0]), .in_ready(ready[0]),
        .in_key(key[0]), .in_joy(joy[0]), .in_trig(trig[0]),
        .tx_line(tx[0]), .busy(busy[0]), .frame_done(done[0]));
    pad_ctrl_tx #(.CLK_DIV(16), .GAP_BITS(2)) u1 (
        .clk(clk), .reset(rst[1]), .in_valid(valid[1]), .in_ready(ready[1]),
        .in_key(key[1]), .in_joy(joy[1]), .in_trig(trig[1]),
        .tx_line(tx[1]), .busy(busy[1]), .frame_done(done[1]));
    pad_ctrl_tx #(.CLK_DIV(2), .GAP_BITS(0)) u2 (
        .clk(clk), .reset(rst[2]), .in_valid(valid[2]), .in_ready(ready[2]),
        .in_key(key[2]), .in_joy(joy[2]), .in_trig(trig[2]),
        .tx_line(tx[2]), .busy(busy[2]), .frame_done(done[2]));

    initial forever #5 clk = ~clk;

    function automatic int dv(input int i);
        case (i)
            0:       return 4;
            1:       return 16;
            default: return 2;
        endcase
    endfunction

    function automatic int gp(input int i);
        return (i == 2) ? 0 : 2;
    endfunction

    task automatic chkb(input string nm, input int i, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (dut %0d, cycle %0d): got %b, want %b", nm, i, cyc, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int i, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (dut %0d, cycle %0d): got %0d, want %0d", nm, i, cyc, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input int i, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (dut %0d, cycle %0d): got %h, want %h", nm, i, cyc, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm, input int i);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (dut %0d, cycle %0d): got no event, want event within bound", nm, i, cyc);
    endtask

    // ---------------- behavioural model ----------------
    // Frame view: after an accept, cycle n (1-based) lies in bit period (n-1)/CLK_DIV:
    // period 0 start, 1..80 payload bits, 81 parity, 82 stop, then the gap.
    logic        m_act [N];
    logic        m_rdy [N];
    int          m_n   [N];
    logic [79:0] m_pay [N];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < N; i++) begin
            if (rst[i]) begin
                m_act[i] <= 1'b0;
                m_rdy[i] <= 1'b0;
            end else if (m_act[i]) begin
                if (m_n[i] >= (83 + gp(i)) * dv(i)) begin
                    m_act[i] <= 1'b0;
                    m_rdy[i] <= 1'b1;
                end else begin
                    m_n[i] <= m_n[i] + 1;
                end
            end else if (valid[i] && m_rdy[i]) begin
                m_act[i] <= 1'b1;
                m_rdy[i] <= 1'b0;
                m_n[i]   <= 1;
                m_pay[i] <= {trig[i], joy[i], key[i]};
            end else begin
                m_rdy[i] <= 1'b1;
            end
        end
    end

    // ---------------- compare process + DUT event log ----------------
    int d_acc  [N] = '{0, 0, 0};
    int d_last [N] = '{0, 0, 0};
    int d_int  [N] = '{0, 0, 0};
    int d_done [N] = '{0, 0, 0};
    logic [79:0] q1 [$];

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                logic etx;
                logic ebusy;
                logic erdy;
                logic edone;
                int   p;
                if (!m_act[i]) begin
                    etx = 1'b1; ebusy = 1'b0; erdy = m_rdy[i]; edone = 1'b0;
                end else begin
                    p     = (m_n[i] - 1) / dv(i);
                    ebusy = 1'b1;
                    erdy  = 1'b0;
                    edone = (m_n[i] == 83 * dv(i));
                    if (p == 0)       etx = 1'b0;
                    else if (p <= 80) etx = m_pay[i][p-1];
                    else if (p == 81) etx = ^m_pay[i];
                    else              etx = 1'b1;
                end
                chkb("tx_line", i, tx[i], etx);
                chkb("busy", i, busy[i], ebusy);
                chkb("in_ready", i, ready[i], erdy);
                chkb("frame_done", i, done[i], edone);
                if (valid[i] === 1'b1 && ready[i] === 1'b1 && rst[i] === 1'b0) begin
                    if (d_acc[i] > 0) d_int[i] <= cyc - d_last[i];
                    d_last[i] <= cyc;
                    d_acc[i]  <= d_acc[i] + 1;
                    if (i == 1) q1.push_back({trig[1], joy[1], key[1]});
                end
                if (done[i] === 1'b1) d_done[i] <= d_done[i] + 1;
            end
        end
    end

    // ---------------- mid-bit sampling receiver on instance 1 ----------------
    int          rx_cnt    = 0;
    logic        rx_on     = 1'b0;
    logic [81:0] rx_bits   = '0;
    int          rx_frames = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            if (!rx_on) begin
                if (tx[1] === 1'b0) begin
                    rx_on  <= 1'b1;
                    rx_cnt <= 1;
                end
            end else begin
                if (rx_cnt % 16 == 8 && rx_cnt / 16 < 82) rx_bits[rx_cnt/16] <= tx[1];
                if (rx_cnt == 82 * 16 + 8) begin
                    logic [79:0] exp_pay;
                    rx_on     <= 1'b0;
                    rx_frames <= rx_frames + 1;
                    if (q1.size() == 0) begin
                        timeout_fail("rx_unexpected_frame", 1);
                    end else begin
                        exp_pay = q1.pop_front();
                        chkw("rx_payload", 1, rx_bits[80:1], exp_pay);
                        chkb("rx_parity", 1, rx_bits[81], ^exp_pay);
                    end
                    chkb("rx_start", 1, rx_bits[0], 1'b0);
                    chkb("rx_stop", 1, tx[1], 1'b1);
                end
                rx_cnt <= rx_cnt + 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a snapshot until accepted; afterwards cycle index n counts from the accept.
    task automatic send(input int i, input logic [31:0] k, input logic [31:0] j, input logic [15:0] t);
        int w = 0;
        key[i] = k; joy[i] = j; trig[i] = t; valid[i] = 1'b1;
        while (ready[i] !== 1'b1 && w < 4000) begin
            tick();
            w++;
        end
        if (w >= 4000) timeout_fail("send_timeout", i);
        tick();
        valid[i] = 1'b0;
        base = cyc - 1;
    endtask

    task automatic at_n(input int n);
        while (cyc - base < n) tick();
    endtask

    task automatic wait_idle(input int i);
        int w = 0;
        while (!(ready[i] === 1'b1 && busy[i] === 1'b0) && w < 4000) begin
            tick();
            w++;
        end
        if (w >= 4000) timeout_fail("idle_timeout", i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog (cycle %0d): got no finish, want finish", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int acc0;
        int dn0;
        int a2;
        for (int i = 0; i < N; i++) begin
            rst[i] = 1'b1; valid[i] = 1'b0; key[i] = '0; joy[i] = '0; trig[i] = '0;
        end
        tick();
        chk_en = 1'b1;
        tick();
        chkb("reset_tx", 0, tx[0], 1'b1);
        chkb("reset_ready", 0, ready[0], 1'b0);
        chkb("reset_busy", 0, busy[0], 1'b0);
        for (int i = 0; i < N; i++) rst[i] = 1'b0;
        tick();
        chkb("ready_after_reset", 0, ready[0], 1'b1);

        // single frame: payload popcount 2+4+8 = 14, so the parity bit is 0
        send(0, 32'h1000_0001, 32'h8080_8080, 16'h00FF);
        chkb("t1_start_tx", 0, tx[0], 1'b0);
        chkb("t1_busy", 0, busy[0], 1'b1);
        chkb("t1_ready_low", 0, ready[0], 1'b0);
        at_n(4);   chkb("t1_start_end", 0, tx[0], 1'b0);
        at_n(5);   chkb("t1_bit0", 0, tx[0], 1'b1);
        at_n(9);   chkb("t1_bit1", 0, tx[0], 1'b0);
        at_n(117); chkb("t1_bit28", 0, tx[0], 1'b1);
        at_n(261); chkb("t1_bit64", 0, tx[0], 1'b1);
        at_n(293); chkb("t1_bit72", 0, tx[0], 1'b0);
        at_n(325); chkb("t1_parity", 0, tx[0], 1'b0);
        at_n(332); chkb("t1_done", 0, done[0], 1'b1);
        chkb("t1_stop", 0, tx[0], 1'b1);
        at_n(333); chkb("t1_done_end", 0, done[0], 1'b0);
        at_n(340); chkb("t1_ready_gap", 0, ready[0], 1'b0);
        chkb("t1_busy_gap", 0, busy[0], 1'b1);
        at_n(341); chkb("t1_ready_back", 0, ready[0], 1'b1);
        chkb("t1_busy_end", 0, busy[0], 1'b0);

        // a second snapshot offered mid-DATA is ignored
        acc0 = d_acc[0];
        send(0, 32'hA5A5_0F0F, 32'h1234_5678, 16'hBEEF);
        at_n(200);
        key[0] = 32'h5A5A_F0F0; joy[0] = 32'hFFFF_0000; trig[0] = 16'h4141; valid[0] = 1'b1;
        repeat (3) tick();
        valid[0] = 1'b0;
        wait_idle(0);
        repeat (20) tick();
        chki("t2_accepts", 0, d_acc[0] - acc0, 1);

        // reset at DATA bit 40 abandons the frame
        dn0 = d_done[0];
        send(0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 16'h7E57);
        at_n(165);
        rst[0] = 1'b1;
        tick();
        chkb("t3_tx", 0, tx[0], 1'b1);
        chkb("t3_busy", 0, busy[0], 1'b0);
        chkb("t3_ready", 0, ready[0], 1'b0);
        chkb("t3_done", 0, done[0], 1'b0);
        tick();
        chkb("t3_ready_held", 0, ready[0], 1'b0);
        rst[0] = 1'b0;
        tick();
        chkb("t3_ready_release", 0, ready[0], 1'b1);
        repeat (400) tick();
        chki("t3_no_done", 0, d_done[0] - dn0, 0);

        // all-zeros and all-ones payloads both carry parity 0
        send(0, 32'h0, 32'h0, 16'h0);
        at_n(321); chkb("t4_zero_bit79", 0, tx[0], 1'b0);
        at_n(326); chkb("t4_zero_parity", 0, tx[0], 1'b0);
        wait_idle(0);
        send(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF);
        at_n(321); chkb("t4_ones_bit79", 0, tx[0], 1'b1);
        at_n(326); chkb("t4_ones_parity", 0, tx[0], 1'b0);
        wait_idle(0);

        // loopback through the sampling receiver
        for (int f = 0; f < 30; f++) begin
            send(1, $urandom, $urandom, 16'($urandom));
        end
        wait_idle(1);
        repeat (20) tick();
        chki("t5_frames", 1, rx_frames, 30);
        chki("t5_queue_empty", 1, q1.size(), 0);

        // back-to-back with in_valid held high and data changing every cycle
        a2 = d_acc[2];
        valid[2] = 1'b1;
        for (int c = 0; c < 600; c++) begin
            key[2] = $urandom; joy[2] = $urandom; trig[2] = 16'($urandom);
            tick();
        end
        valid[2] = 1'b0;
        chki("t6_accepts", 2, d_acc[2] - a2, 4);
        chki("t6_spacing", 2, d_int[2], 167);
        wait_idle(2);
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
